fetch_unit: RTL

//  Instruction-fetch front end; the consumer of the redirect target (final_pc) computed by the

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch: the instruction word tagged with the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits of a target are ignored.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush. Head is visible
// combinationally and reads as zero while empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wr_data,
  output fetch_entry_t  rd_data,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  // Overflowing pushes and underflowing pops are ignored rather than corrupting state.
  assign do_push = push && (count_reg != CW'(DEPTH));
  assign do_pop  = pop && (count_reg != '0);

  // Storage array; a flush makes any same-cycle write irrelevant.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count   = count_reg;
  assign rd_data = (count_reg != '0) ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited word
// requests, tags responses with their PC and buffers them for decode.
// Redirects flush everything local and mark all outstanding requests stale.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   drop_reg, drop_next;
  logic            started_reg;

  logic            accept;
  logic            keep_resp;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   out_count;
  logic [CW-1:0]   pcq_count;
  fetch_entry_t    pcq_in, pcq_head;
  fetch_entry_t    out_in, out_head;

  // Every issued request reserves a buffer slot, so the output FIFO can never overflow.
  // started_reg holds requests off while reset is asserted and for the first edge after.
  assign credit_used    = {1'b0, inflight_reg} + {1'b0, out_count};
  assign imem_req_valid = started_reg && (credit_used < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response is kept only when no redirect is killing it and no stale requests precede it.
  assign keep_resp = imem_resp_valid && !redirect_valid && (drop_reg == '0) && (pcq_count != '0);

  // Next-state for PC and the in-flight / stale counters.
  always_comb begin
    inflight_next = inflight_reg + CW'(accept) - CW'(imem_resp_valid);
    pc_next       = pc_reg;
    drop_next     = drop_reg;
    if (redirect_valid) begin
      pc_next   = align_word(redirect_pc);
      drop_next = inflight_next;
    end else begin
      if (accept) pc_next = pc_reg + 32'd4;
      if (imem_resp_valid && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
    end
  end

  // Architectural fetch state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
      started_reg  <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
      started_reg  <= 1'b1;
    end
  end

  // Response entry: PC from the tag queue head, instruction from memory.
  always_comb begin
    pcq_in       = '{pc: pc_reg, instr: '0};
    out_in       = pcq_head;
    out_in.instr = imem_resp_data;
  end

  // PC tag queue: one entry per live (non-stale) request.
  fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (accept && !redirect_valid),
    .pop     (keep_resp),
    .flush   (redirect_valid),
    .wr_data (pcq_in),
    .rd_data (pcq_head),
    .count   (pcq_count)
  );

  // Instruction buffer toward decode.
  fetch_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (keep_resp),
    .pop     (if_valid && if_ready),
    .flush   (redirect_valid),
    .wr_data (out_in),
    .rd_data (out_head),
    .count   (out_count)
  );

  assign if_valid = (out_count != '0);
  assign if_instr = out_head.instr;
  assign if_pc    = out_head.pc;

endmodule
